// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the UART receive controller
//
// Purpose: FSM state and evaluation-kind encodings, counter widths, legal
// oversampling ratios, and the mapping from a bit period's state to the kind
// of evaluation its voted bit receives.
// Ports: none (package).

package uart_rx_pkg;

  localparam int EDGE_W = 6;
  localparam int BIT_W  = 4;

  localparam logic [EDGE_W-1:0] PRESCALE_8  = 6'd8;
  localparam logic [EDGE_W-1:0] PRESCALE_16 = 6'd16;
  localparam logic [EDGE_W-1:0] PRESCALE_32 = 6'd32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    CHECK  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    EV_START  = 2'd0,
    EV_DATA   = 2'd1,
    EV_PARITY = 2'd2,
    EV_STOP   = 2'd3
  } eval_kind_t;

  // The bit period that just wrapped belongs to the state we were in, so that
  // state decides how the voted bit arriving next cycle is consumed.
  function automatic eval_kind_t kind_of(input state_t st);
    case (st)
      START:   return EV_START;
      DATA:    return EV_DATA;
      PARITY:  return EV_PARITY;
      default: return EV_STOP;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - signal bundle between the RX controller and its surroundings
//
// Purpose: groups the serial input, frame configuration, sampler handshake
// and received-word outputs of uart_rx_ctrl.
// Modports:
//   master - the controller: consumes rx_in/config/sampled_bit, drives counters and results
//   slave  - the environment (line, sampler, consumer of p_data)

interface uart_rx_ctrl_if #(
  parameter int DATA_WIDTH = 8
);

  logic                            rx_in;
  logic [uart_rx_pkg::EDGE_W-1:0]  prescale;
  logic                            par_en;
  logic                            par_typ;
  logic                            sampled_bit;
  logic [uart_rx_pkg::EDGE_W-1:0]  edge_cnt;
  logic [uart_rx_pkg::BIT_W-1:0]   bit_cnt;
  logic [DATA_WIDTH-1:0]           p_data;
  logic                            data_valid;
  logic                            par_err;
  logic                            stop_err;
  logic                            busy;

  modport master (
    input  rx_in, prescale, par_en, par_typ, sampled_bit,
    output edge_cnt, bit_cnt, p_data, data_valid, par_err, stop_err, busy
  );

  modport slave (
    output rx_in, prescale, par_en, par_typ, sampled_bit,
    input  edge_cnt, bit_cnt, p_data, data_valid, par_err, stop_err, busy
  );

endinterface

// File: rtl/uart_rx_edge_bit_counter.sv
// rtl/uart_rx_edge_bit_counter.sv - oversample edge counter and frame bit counter
//
// Purpose: counts oversample edges within a bit and bits within a frame.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   en        - advance the counters this cycle
//   clr       - synchronous clear, wins over en
//   prescale  - oversampling ratio
//   edge_cnt  - oversample index within the current bit
//   bit_cnt   - index of the current bit in the frame
//   wrap      - strobe: last edge of the current bit while enabled

module uart_rx_edge_bit_counter
  import uart_rx_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [EDGE_W-1:0] prescale,
  output logic [EDGE_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]  bit_cnt,
  output logic              wrap
);

  logic at_end;

  // The all-ones term keeps the counter wrapping if prescale is illegal or
  // shrinks below the current count; prescale==0 also lands on 63.
  assign at_end = (edge_cnt == (prescale - EDGE_W'(1))) || (edge_cnt == '1);
  assign wrap   = en && at_end;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (clr) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (en) begin
      if (at_end) begin
        edge_cnt <= '0;
        bit_cnt  <= bit_cnt + BIT_W'(1);
      end else begin
        edge_cnt <= edge_cnt + EDGE_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive controller: framing FSM, deserializer, checks
//
// Purpose: detects the start edge, runs the edge/bit counters for the
// sampler, deserializes voted bits LSB-first, checks start/parity/stop and
// pulses data_valid, par_err or stop_err one cycle after the frame's CHECK.
// Ports:
//   clk  - oversampling clock
//   rst  - asynchronous active-low reset
//   bus  - uart_rx_ctrl_if.master: rx_in, prescale, par_en, par_typ,
//          sampled_bit in; edge_cnt, bit_cnt, p_data, data_valid, par_err,
//          stop_err, busy out

module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_ctrl_if.master bus
);

  localparam logic [BIT_W-1:0] LAST_DATA_BIT = BIT_W'(DATA_WIDTH);

  state_t                state;
  state_t                state_nxt;
  logic                  cnt_en;
  logic                  cnt_clr;
  logic                  wrap;
  logic                  busy_c;
  logic                  false_start;
  logic [EDGE_W-1:0]     edge_cnt;
  logic [BIT_W-1:0]      bit_cnt;

  logic                  eval_pend;
  eval_kind_t            eval_kind;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  par_fail;
  logic                  chk_par;
  logic                  chk_stop;
  logic                  chk_ok;
  logic [DATA_WIDTH-1:0] p_data_q;
  logic                  data_valid_q;
  logic                  par_err_q;
  logic                  stop_err_q;

  uart_rx_edge_bit_counter u_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (cnt_en),
    .clr      (cnt_clr),
    .prescale (bus.prescale),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .wrap     (wrap)
  );

  // Start bit voted high: the first DATA cycle is where this is seen.
  assign false_start = (state == DATA) && eval_pend && (eval_kind == EV_START)
                       && bus.sampled_bit;

  // Clearing at the stop wrap gives CHECK its edge_cnt=0 / bit_cnt=0 cycle.
  assign cnt_clr = false_start || ((state == STOP) && wrap);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!bus.rx_in) state_nxt = START;
      START:   if (wrap) state_nxt = DATA;
      DATA: begin
        if (false_start) begin
          state_nxt = IDLE;
        end else if (wrap && (bit_cnt == LAST_DATA_BIT)) begin
          state_nxt = bus.par_en ? PARITY : STOP;
        end
      end
      PARITY:  if (wrap) state_nxt = STOP;
      STOP:    if (wrap) state_nxt = CHECK;
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The detection cycle itself is edge 0 of the start bit, so the counter
  // already runs while still in IDLE.
  always_comb begin
    busy_c = 1'b0;
    cnt_en = 1'b0;
    case (state)
      IDLE:                     cnt_en = !bus.rx_in;
      START, DATA, PARITY, STOP: begin
        busy_c = 1'b1;
        cnt_en = 1'b1;
      end
      CHECK:                    busy_c = 1'b1;
      default: begin
        busy_c = 1'b0;
        cnt_en = 1'b0;
      end
    endcase
  end

  assign chk_par  = par_fail & bus.par_en;
  assign chk_stop = !bus.sampled_bit;
  assign chk_ok   = !(chk_par | chk_stop);

  // The sampler's vote for a bit lands one cycle after that bit's wrap, so
  // each wrap arms eval_pend and records which kind of bit is coming.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      eval_pend    <= 1'b0;
      eval_kind    <= EV_START;
      shift_reg    <= '0;
      par_fail     <= 1'b0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stop_err_q   <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stop_err_q   <= 1'b0;
      eval_pend    <= wrap && !false_start;
      if (wrap) begin
        eval_kind <= kind_of(state);
      end
      // Frames without parity must not inherit a stale failure.
      if ((state == IDLE) && !bus.rx_in) begin
        par_fail <= 1'b0;
      end
      if (eval_pend) begin
        case (eval_kind)
          EV_DATA:   shift_reg <= {bus.sampled_bit, shift_reg[DATA_WIDTH-1:1]};
          EV_PARITY: par_fail  <= (^shift_reg) ^ bus.par_typ ^ bus.sampled_bit;
          EV_STOP: begin
            par_err_q    <= chk_par;
            stop_err_q   <= chk_stop;
            data_valid_q <= chk_ok;
            if (chk_ok) begin
              p_data_q <= shift_reg;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.edge_cnt   = edge_cnt;
  assign bus.bit_cnt    = bit_cnt;
  assign bus.busy       = busy_c;
  assign bus.p_data     = p_data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.par_err    = par_err_q;
  assign bus.stop_err   = stop_err_q;

endmodule
